root_feeder: RTL and testbench
==============================

ROOT_FEEDER -- requirements
Module: root_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request queue entries (power of two, 2..16), in-flight entry included.
REQ-002 SHALL have parameter TIMEOUT, default 255, WAIT-state cycle limit (1..255), used only under REQ-030.
REQ-003 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: req_valid in 1, req_ready out 1, req_radicand in 10, req_degree in 3; upstream request handshake.
REQ-006 SHALL have ports: root_in_valid out 1, root_in_data_1 out 10, root_in_data_2 out 3; drive to root engine.
REQ-007 SHALL have ports: root_out_valid in 1, root_out_data in 20; root engine result, 10.10 fixed point.
REQ-008 SHALL have ports: rsp_valid out 1, rsp_ready in 1, rsp_data out 20, rsp_radicand out 10, rsp_degree out 3, rsp_err out 1; downstream response.
REQ-009 SHALL have port: level out $clog2(DEPTH)+1, current queue occupancy.

Function
REQ-010 Request accepted (pushed) on cycle where req_valid && req_ready; req_ready = (level < DEPTH) || pop this cycle.
REQ-011 Queue SHALL be FIFO with wrapping read/write pointers; push and pop in same cycle leave level unchanged, legal at full and at one.
REQ-012 FSM states IDLE, ISSUE, WAIT, RESP; reset state IDLE.
REQ-013 IDLE -> ISSUE when level != 0 and head degree != 0; IDLE -> RESP when head degree == 0 (bypass, no engine activity).
REQ-014 ISSUE lasts exactly one cycle, root_in_valid = 1 only in ISSUE; then -> WAIT.
REQ-015 root_in_data_1/2 SHALL equal head radicand/degree and stay constant from ISSUE through the cycle root_out_valid is sampled in WAIT.
REQ-016 WAIT -> RESP on root_out_valid; result register captures root_out_data verbatim, rsp_err = 0.
REQ-017 root_out_valid outside WAIT SHALL be ignored (no state, data or count change).
REQ-018 Bypass (degree 0): rsp_data = 20'h00000, rsp_err = 1.
REQ-019 In RESP, rsp_valid = 1; rsp_data, rsp_radicand, rsp_degree, rsp_err held stable until rsp_valid && rsp_ready.
REQ-020 On rsp_valid && rsp_ready: head popped, -> IDLE; next issue no earlier than the following cycle.
REQ-021 Exactly one request in flight at the engine; no ISSUE while in WAIT or RESP.
REQ-022 Minimum latency acceptance-to-rsp_valid into empty queue: engine latency + 3 cycles; bypass: 2 cycles.

Reset
REQ-023 rst asserted at any cycle, including mid-WAIT or mid-RESP, SHALL on next edge: state IDLE, level 0, pointers 0, queue contents discarded.
REQ-024 Reset values: req_ready 0 during rst then 1, root_in_valid 0, root_in_data_1/2 0, rsp_valid 0, rsp_data 0, rsp_radicand 0, rsp_degree 0, rsp_err 0, level 0.
REQ-025 Engine SHALL be reset together with this block; stale root_out_valid after reset falls under REQ-017.

Configuration
REQ-030 Macro ROOT_FEEDER_TIMEOUT_EN defined: 8-bit watchdog counts WAIT cycles, cleared on WAIT entry; on reaching TIMEOUT without root_out_valid -> RESP with rsp_data 20'hFFFFF, rsp_err 1; later root_out_valid ignored per REQ-017.
REQ-031 Macro undefined: no watchdog logic; WAIT exits only on root_out_valid.

Verification
REQ-040 Radicand 16, degree 2, engine model 40-cycle latency returning 20'h01000 -> one root_in_valid pulse, rsp_data 20'h01000, rsp_err 0, rsp_radicand 16, rsp_degree 2.
REQ-041 DEPTH=4, five back-to-back requests, engine stalled -> req_ready low after 4th push, 5th accepted same cycle as 1st response pop, level stays 4.
REQ-042 Degree 0, radicand 7 -> no root_in_valid, rsp_valid after 2 cycles, rsp_data 0, rsp_err 1.
REQ-043 rsp_ready held low 10 cycles in RESP -> rsp outputs constant, no second root_in_valid until pop.
REQ-044 rst pulsed 5 cycles after ISSUE, then spurious root_out_valid -> level 0, rsp_valid never asserted.
REQ-045 With ROOT_FEEDER_TIMEOUT_EN, TIMEOUT=20, engine silent -> rsp_valid 20 cycles after WAIT entry, rsp_data 20'hFFFFF, rsp_err 1.

Source files
------------

// File: rtl/root_feeder.sv
// Request queue and sequencer feeding a single root engine, one request in flight at a time.
// Optional WAIT-state watchdog enabled by defining ROOT_FEEDER_TIMEOUT_EN.
`timescale 1ns/1ps
module root_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [9:0]              req_radicand,
    input  logic [2:0]              req_degree,
    output logic                    root_in_valid,
    output logic [9:0]              root_in_data_1,
    output logic [2:0]              root_in_data_2,
    input  logic                    root_out_valid,
    input  logic [19:0]             root_out_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [19:0]             rsp_data,
    output logic [9:0]              rsp_radicand,
    output logic [2:0]              rsp_degree,
    output logic                    rsp_err,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("root_feeder: illegal DEPTH or TIMEOUT");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    typedef struct packed {
        logic [9:0] radicand;
        logic [2:0] degree;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [9:0]      in_rad_q, in_rad_d;
    logic [2:0]      in_deg_q, in_deg_d;
    logic [19:0]     rsp_data_q, rsp_data_d;
    logic [9:0]      rsp_rad_q, rsp_rad_d;
    logic [2:0]      rsp_deg_q, rsp_deg_d;
    logic            rsp_err_q, rsp_err_d;
    logic            push, pop;

`ifdef ROOT_FEEDER_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
    logic [7:0]      wd_cnt_q, wd_cnt_d;
`endif

    assign head      = mem[rd_ptr_q];
    assign pop       = (state_q == RESP) && rsp_ready;
    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign req_ready = !rst && ((level_q < LW'(DEPTH)) || pop);
    assign push      = req_valid && req_ready;

    assign root_in_valid  = (state_q == ISSUE);
    assign root_in_data_1 = in_rad_q;
    assign root_in_data_2 = in_deg_q;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_data       = rsp_data_q;
    assign rsp_radicand   = rsp_rad_q;
    assign rsp_degree     = rsp_deg_q;
    assign rsp_err        = rsp_err_q;
    assign level          = level_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + (push ? PW'(1) : PW'(0));
        rd_ptr_d   = rd_ptr_q + (pop  ? PW'(1) : PW'(0));
        level_d    = level_q;
        in_rad_d   = in_rad_q;
        in_deg_d   = in_deg_q;
        rsp_data_d = rsp_data_q;
        rsp_rad_d  = rsp_rad_q;
        rsp_deg_d  = rsp_deg_q;
        rsp_err_d  = rsp_err_q;
`ifdef ROOT_FEEDER_TIMEOUT_EN
        wd_cnt_d   = wd_cnt_q;
`endif

        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    rsp_rad_d = head.radicand;
                    rsp_deg_d = head.degree;
                    if (head.degree == 3'd0) begin
                        rsp_data_d = 20'h00000;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end else begin
                        in_rad_d = head.radicand;
                        in_deg_d = head.degree;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef ROOT_FEEDER_TIMEOUT_EN
                wd_cnt_d = 8'd0;
`endif
            end
            WAIT: begin
                if (root_out_valid) begin
                    rsp_data_d = root_out_data;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end
`ifdef ROOT_FEEDER_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    rsp_data_d = 20'hFFFFF;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                if (pop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_rad_q   <= '0;
            in_deg_q   <= '0;
            rsp_data_q <= '0;
            rsp_rad_q  <= '0;
            rsp_deg_q  <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            in_rad_q   <= in_rad_d;
            in_deg_q   <= in_deg_d;
            rsp_data_q <= rsp_data_d;
            rsp_rad_q  <= rsp_rad_d;
            rsp_deg_q  <= rsp_deg_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifdef ROOT_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= 8'd0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    // NOTE: queue storage has no reset; level and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= '{radicand: req_radicand, degree: req_degree};
        end
    end

endmodule

// File: tb/tb_root_feeder.sv
// Directed self-checking bench for root_feeder; the bench itself plays the root engine.
`timescale 1ns/1ps
module tb_root_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_radicand;
    logic [2:0]  req_degree;
    logic        root_in_valid;
    logic [9:0]  root_in_data_1;
    logic [2:0]  root_in_data_2;
    logic        root_out_valid;
    logic [19:0] root_out_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [19:0] rsp_data;
    logic [9:0]  rsp_radicand;
    logic [2:0]  rsp_degree;
    logic        rsp_err;
    logic [2:0]  level;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    root_feeder #(.DEPTH(4), .TIMEOUT(20)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_radicand   (req_radicand),
        .req_degree     (req_degree),
        .root_in_valid  (root_in_valid),
        .root_in_data_1 (root_in_data_1),
        .root_in_data_2 (root_in_data_2),
        .root_out_valid (root_out_valid),
        .root_out_data  (root_out_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_radicand   (rsp_radicand),
        .rsp_degree     (rsp_degree),
        .rsp_err        (rsp_err),
        .level          (level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for exactly one edge; ends one cycle after acceptance.
    task automatic push(input logic [9:0] rad, input logic [2:0] deg);
        req_valid    = 1'b1;
        req_radicand = rad;
        req_degree   = deg;
        #1;
        check("push_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    // Engine with one-cycle latency plus an immediate response pop.
    task automatic serve(input logic [9:0] rad, input logic [2:0] deg, input logic [19:0] ret);
        int n = 0;
        while (root_in_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check("serve_issue", root_in_valid, 1);
        check("serve_in_rad", root_in_data_1, rad);
        check("serve_in_deg", root_in_data_2, deg);
        step();
        check("serve_wait_no_issue", root_in_valid, 0);
        root_out_valid = 1'b1;
        root_out_data  = ret;
        step();
        root_out_valid = 1'b0;
        root_out_data  = 20'h0;
        check("serve_rsp_valid", rsp_valid, 1);
        check("serve_rsp_data", rsp_data, ret);
        check("serve_rsp_rad", rsp_radicand, rad);
        check("serve_rsp_deg", rsp_degree, deg);
        check("serve_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("serve_popped", rsp_valid, 0);
    endtask

    initial begin
        int t0;
        int pulses;
        int rspv;
        int unstable;

        rst            = 1'b1;
        req_valid      = 1'b0;
        req_radicand   = '0;
        req_degree     = '0;
        root_out_valid = 1'b0;
        root_out_data  = '0;
        rsp_ready      = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 0);
        step();
        step();
        check("rst_req_ready_held", req_ready, 0);
        check("rst_level", level, 0);
        check("rst_root_in_valid", root_in_valid, 0);
        check("rst_root_in_data_1", root_in_data_1, 0);
        check("rst_root_in_data_2", root_in_data_2, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_radicand", rsp_radicand, 0);
        check("rst_rsp_degree", rsp_degree, 0);
        check("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", req_ready, 1);

        // Radicand 16, degree 2, engine latency 40.
        push(10'd16, 3'd2);
        t0 = cyc;
        check("t1_level", level, 1);
        check("t1_idle_no_issue", root_in_valid, 0);
        step();
        check("t1_issue", root_in_valid, 1);
        check("t1_in_rad", root_in_data_1, 16);
        check("t1_in_deg", root_in_data_2, 2);
        pulses = 0;
        rspv = 0;
        unstable = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            pulses += int'(root_in_valid);
            rspv += int'(rsp_valid);
            if (root_in_data_1 !== 10'd16 || root_in_data_2 !== 3'd2) unstable++;
        end
        root_out_valid = 1'b1;
        root_out_data  = 20'h01000;
        step();
        root_out_valid = 1'b0;
        root_out_data  = 20'h0;
        check("t1_extra_pulses", pulses, 0);
        check("t1_early_rsp", rspv, 0);
        check("t1_in_data_unstable", unstable, 0);
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_latency", cyc - t0 + 1, 43);
        check("t1_rsp_data", rsp_data, 20'h01000);
        check("t1_rsp_err", rsp_err, 0);
        check("t1_rsp_rad", rsp_radicand, 16);
        check("t1_rsp_deg", rsp_degree, 2);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t1_popped_valid", rsp_valid, 0);
        check("t1_popped_level", level, 0);

        // Degree-0 bypass.
        push(10'd7, 3'd0);
        t0 = cyc;
        check("t2_no_rsp_yet", rsp_valid, 0);
        check("t2_no_issue_idle", root_in_valid, 0);
        step();
        check("t2_no_issue", root_in_valid, 0);
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_latency", cyc - t0 + 1, 2);
        check("t2_rsp_data", rsp_data, 0);
        check("t2_rsp_err", rsp_err, 1);
        check("t2_rsp_rad", rsp_radicand, 7);
        check("t2_rsp_deg", rsp_degree, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t2_popped_level", level, 0);

        // Response backpressure with spurious engine pulses and a queued request.
        push(10'd100, 3'd3);
        step();
        check("t3_issue", root_in_valid, 1);
        step();
        root_out_valid = 1'b1;
        root_out_data  = 20'h12345;
        step();
        for (int i = 0; i < 10; i++) begin
            root_out_valid = (i == 3 || i == 4);
            root_out_data  = 20'hBAD00;
            req_valid      = (i == 5);
            req_radicand   = 10'd50;
            req_degree     = 3'd2;
            #1;
            check("t3_hold_valid", rsp_valid, 1);
            check("t3_hold_data", rsp_data, 20'h12345);
            check("t3_hold_rad", rsp_radicand, 100);
            check("t3_hold_deg", rsp_degree, 3);
            check("t3_hold_err", rsp_err, 0);
            check("t3_hold_no_issue", root_in_valid, 0);
            step();
        end
        root_out_valid = 1'b0;
        root_out_data  = 20'h0;
        req_valid      = 1'b0;
        check("t3_level_two", level, 2);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t3_after_pop_level", level, 1);
        check("t3_after_pop_no_issue", root_in_valid, 0);
        step();
        check("t3_next_issue_cycle", root_in_valid, 1);
        serve(10'd50, 3'd2, 20'h00ABC);
        check("t3_drained", level, 0);

        // Five back-to-back requests against a stalled engine.
        for (int i = 1; i <= 4; i++) begin
            req_valid    = 1'b1;
            req_radicand = 10'(i);
            req_degree   = 3'(i);
            #1;
            check("t4_fill_ready", req_ready, 1);
            step();
        end
        req_radicand = 10'd5;
        req_degree   = 3'd5;
        #1;
        check("t4_full_level", level, 4);
        check("t4_full_not_ready", req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_stall_not_ready", req_ready, 0);
            check("t4_stall_level", level, 4);
        end
        root_out_valid = 1'b1;
        root_out_data  = 20'h00111;
        step();
        root_out_valid = 1'b0;
        root_out_data  = 20'h0;
        check("t4_rsp1_valid", rsp_valid, 1);
        check("t4_rsp1_rad", rsp_radicand, 1);
        check("t4_rsp1_data", rsp_data, 20'h00111);
        check("t4_ready_before_pop", req_ready, 0);
        rsp_ready = 1'b1;
        #1;
        check("t4_ready_on_pop", req_ready, 1);
        step();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("t4_level_stays_4", level, 4);
        serve(10'd2, 3'd2, 20'h00222);
        serve(10'd3, 3'd3, 20'h00333);
        serve(10'd4, 3'd4, 20'h00444);
        serve(10'd5, 3'd5, 20'h00555);
        check("t4_drained", level, 0);

        // Reset in mid-WAIT followed by a stale engine pulse.
        push(10'd9, 3'd2);
        step();
        check("t5_issue", root_in_valid, 1);
        push(10'd11, 3'd1);
        for (int i = 0; i < 4; i++) step();
        check("t5_level_before_rst", level, 2);
        rst = 1'b1;
        #1;
        check("t5_rst_not_ready", req_ready, 0);
        step();
        rst = 1'b0;
        check("t5_rst_level", level, 0);
        check("t5_rst_rsp_valid", rsp_valid, 0);
        check("t5_rst_in_data", root_in_data_1, 0);
        root_out_valid = 1'b1;
        root_out_data  = 20'h0DEAD;
        pulses = 0;
        rspv = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 1) root_out_valid = 1'b0;
            pulses += int'(root_in_valid);
            rspv += int'(rsp_valid);
        end
        root_out_data = 20'h0;
        check("t5_no_issue", pulses, 0);
        check("t5_no_rsp", rspv, 0);
        check("t5_level_zero", level, 0);
        check("t5_rsp_data_zero", rsp_data, 0);
        push(10'd25, 3'd2);
        serve(10'd25, 3'd2, 20'h05000);

`ifdef ROOT_FEEDER_TIMEOUT_EN
        // Silent engine against the watchdog.
        push(10'd33, 3'd3);
        step();
        check("t6_issue", root_in_valid, 1);
        step();
        rspv = 0;
        for (int k = 1; k < 20; k++) begin
            step();
            rspv += int'(rsp_valid);
        end
        check("t6_no_early_rsp", rspv, 0);
        step();
        check("t6_timeout_valid", rsp_valid, 1);
        check("t6_timeout_data", rsp_data, 20'hFFFFF);
        check("t6_timeout_err", rsp_err, 1);
        check("t6_timeout_rad", rsp_radicand, 33);
        root_out_valid = 1'b1;
        root_out_data  = 20'h00777;
        step();
        root_out_valid = 1'b0;
        root_out_data  = 20'h0;
        check("t6_late_ignored", rsp_data, 20'hFFFFF);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t6_popped_level", level, 0);
`else
        // Without the watchdog, WAIT only leaves on an engine result.
        push(10'd33, 3'd3);
        step();
        check("t6_issue", root_in_valid, 1);
        step();
        rspv = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            rspv += int'(rsp_valid);
        end
        check("t6_no_timeout", rspv, 0);
        root_out_valid = 1'b1;
        root_out_data  = 20'h00777;
        step();
        root_out_valid = 1'b0;
        root_out_data  = 20'h0;
        check("t6_rsp_valid", rsp_valid, 1);
        check("t6_rsp_data", rsp_data, 20'h00777);
        check("t6_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t6_popped_level", level, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
